// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: the FSM state encoding and
// the parity-type constants used by the core and the parity calculator.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity bit generator. It operates on the payload latched at accept, so a
// change on the live input bus cannot disturb the parity of a frame in flight.
module uart_tx_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);
    import uart_tx_pkg::*;

    // Even parity is the XOR reduction; odd parity is its inverse.
    always_comb begin
        par_bit = (par_typ == EVEN) ? (^data) : ~(^data);
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter core: one serial bit per CLK cycle. Frame layout is
// start (0), payload LSB first, optional parity, stop (1). A new frame may be
// accepted in STOP, giving back-to-back frames with no idle gap.
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);
    import uart_tx_pkg::*;

    // A 1-bit payload still needs a 1-bit counter.
    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        bit_cnt_nxt;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic                    par_en_reg;
    logic                    par_typ_reg;
    logic                    par_bit;
    logic                    accept;

    // Requests are only honoured when the line is idle or finishing a stop bit.
    assign accept      = DATA_VALID && ((state == IDLE) || (state == STOP));
    assign bit_cnt_nxt = bit_cnt + 1'b1;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (data_reg),
        .par_typ (par_typ_reg),
        .par_bit (par_bit)
    );

    // Frame sequencer; TX_OUT and Busy are registered with the state so the
    // line never sees combinational glitches.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            TX_OUT      <= 1'b1;
            Busy        <= 1'b0;
            bit_cnt     <= '0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= EVEN;
        end else begin
            case (state)
                IDLE, STOP: begin
                    if (accept) begin
                        state       <= START;
                        TX_OUT      <= 1'b0;
                        Busy        <= 1'b1;
                        data_reg    <= P_DATA;
                        par_en_reg  <= PAR_EN;
                        par_typ_reg <= PAR_TYP;
                        bit_cnt     <= '0;
                    end else begin
                        state  <= IDLE;
                        TX_OUT <= 1'b1;
                        Busy   <= 1'b0;
                    end
                end
                START: begin
                    state   <= DATA;
                    TX_OUT  <= data_reg[0];
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_reg) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt_nxt;
                        TX_OUT  <= data_reg[bit_cnt_nxt];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: directed frames with hand-written line sequences
// pushed into a per-cycle scoreboard; a monitor compares every cycle and
// expects an idle line whenever nothing is queued.
module tb_uart_tx_core;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    // Each entry is {Busy, TX_OUT} for one cycle.
    logic [1:0] exp_q[$];

    uart_tx_core #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: busy,tx = %b expected %b (t=%0t)", name, got, want, $time);
        end
    endtask

    // Seq is written in time order, leftmost (bit len-1) first on the line.
    task automatic push_seq(input logic [15:0] seq, input int len);
        for (int i = len - 1; i >= 0; i--)
            exp_q.push_back({1'b1, seq[i]});
    endtask

    // Called at a negedge: issue a one-cycle request, then scramble the live
    // inputs so any use of unlatched values shows up on the line.
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                        input logic [15:0] seq, input int len);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        DATA_VALID = 1'b1;
        push_seq(seq, len);
        @(negedge CLK);
        DATA_VALID = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pen;
        PAR_TYP    = ~ptyp;
    endtask

    // Monitor: compare the line every cycle just after the active edge.
    initial begin
        logic [1:0] want;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (exp_q.size() > 0) want = exp_q.pop_front();
            else                  want = 2'b01;
            check($sformatf("line_cyc%0d", cyc), {Busy, TX_OUT}, want);
        end
    end

    initial begin
        DATA_VALID = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        RST        = 1'b1;
        #1 RST     = 1'b0;
        #1 check("reset_state", {Busy, TX_OUT}, 2'b01);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // A5, even parity
        send(8'hA5, 1'b1, 1'b0, 16'b01010010101, 11);
        repeat (12) @(negedge CLK);

        // Odd parity corner cases
        send(8'h01, 1'b1, 1'b1, 16'b01000000001, 11);
        repeat (12) @(negedge CLK);
        send(8'h00, 1'b1, 1'b1, 16'b00000000011, 11);
        repeat (12) @(negedge CLK);

        // No parity, all ones
        send(8'hFF, 1'b0, 1'b0, 16'b0111111111, 10);
        repeat (11) @(negedge CLK);

        // Back-to-back: second request lands in the STOP cycle of the first
        send(8'h81, 1'b0, 1'b0, 16'b0100000011, 10);
        repeat (9) @(negedge CLK);
        send(8'h3C, 1'b1, 1'b0, 16'b00011110001, 11);
        repeat (12) @(negedge CLK);

        // Request and data change during DATA must be ignored
        send(8'h5A, 1'b1, 1'b1, 16'b00101101011, 11);
        repeat (2) @(negedge CLK);
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        repeat (12) @(negedge CLK);

        // Reset while data bit 4 (a 0) is on the line
        send(8'hA5, 1'b1, 1'b0, 16'b010100, 6);
        repeat (5) @(negedge CLK);
        check("pre_reset_bit4", {Busy, TX_OUT}, 2'b10);
        RST = 1'b0;
        #1 check("reset_midframe", {Busy, TX_OUT}, 2'b01);
        P_DATA     = 8'hA5;
        DATA_VALID = 1'b1;
        repeat (2) @(negedge CLK);
        DATA_VALID = 1'b0;
        RST        = 1'b1;
        repeat (6) @(negedge CLK);

        // Normal operation resumes after a fresh request
        send(8'hFF, 1'b0, 1'b0, 16'b0111111111, 10);
        repeat (11) @(negedge CLK);

        check("queue_drained", (exp_q.size() == 0) ? 2'b01 : 2'b00, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
